audio_i2s_dac_tx: RTL and testbench

- I2S transmitter for the audio codec DAC path, clocked by the 18.432 MHz audio PLL output and gated by the PLL lock indication.
- Generates BCLK (MCLK/6 = 3.072 MHz) and DACLRCK (48 kHz, 64 BCLK per frame).
- Accepts stereo samples through a valid/ready handshake into a one-entry holding register and serialises them MSB-first in I2S format.
- Holds the codec interface idle until the PLL lock has been stable for a programmable time.

---
 rtl/audio_i2s_dac_tx.sv | 195 +++++++++++++++++++
 tb/tb_audio_i2s_dac_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_dac_tx.sv
// I2S transmitter for the codec DAC path.
// Derives BCLK and DACLRCK from the audio master clock, buffers one stereo
// sample pair in a holding register and shifts it out MSB-first in I2S
// format (one BCLK delay after each DACLRCK edge). The codec interface stays
// idle until the PLL lock has been stable for LOCK_STABLE_CYCLES cycles.
module audio_i2s_dac_tx #(
    parameter int DATA_WIDTH         = 24,
    parameter int BCLK_DIV           = 6,
    parameter int LOCK_STABLE_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic [DATA_WIDTH-1:0] left_data,
    input  logic [DATA_WIDTH-1:0] right_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  aud_bclk,
    output logic                  aud_daclrck,
    output logic                  aud_dacdat,
    output logic                  underrun,
    output logic                  running
);

    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STARTUP   = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic                  lock_meta, lock_s;
    logic [CNT_W-1:0]      stable_cnt, stable_cnt_nx;
    logic [DIV_W-1:0]      div_cnt, div_nx;
    logic [5:0]            bit_cnt, bit_nx;
    logic                  hold_full, hold_full_nx;
    logic [DATA_WIDTH-1:0] hold_left, hold_right;
    logic [DATA_WIDTH-1:0] left_sr, right_sr, sr_sel;
    logic [4:0]            slot_k;
    logic                  active_nx, run_nx, cont_run, load, accept;
    logic                  ready_nx, bclk_nx, lrck_nx, dat_nx, underrun_nx;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Next-state, counter, handshake and registered-output computation.
    always_comb begin
        state_nx      = state;
        stable_cnt_nx = stable_cnt;
        div_nx        = '0;
        bit_nx        = '0;
        hold_full_nx  = hold_full;
        bclk_nx       = 1'b0;
        lrck_nx       = 1'b0;
        dat_nx        = 1'b0;
        sr_sel        = left_sr;
        slot_k        = '0;

        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx      = STARTUP;
                    stable_cnt_nx = '0;
                end
            end
            STARTUP: begin
                if (!lock_s) begin
                    state_nx      = WAIT_LOCK;
                    stable_cnt_nx = '0;
                end else if (stable_cnt == CNT_LAST) begin
                    state_nx = RUN;
                end else begin
                    stable_cnt_nx = stable_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nx      = WAIT_LOCK;
                    stable_cnt_nx = '0;
                end
            end
            default: begin
                state_nx      = WAIT_LOCK;
                stable_cnt_nx = '0;
            end
        endcase

        active_nx = (state_nx == STARTUP) || (state_nx == RUN);
        run_nx    = (state_nx == RUN);
        cont_run  = (state == RUN) && run_nx;
        load      = (state == RUN) && (div_cnt == '0) && (bit_cnt == '0);
        accept    = sample_valid && sample_ready;

        // Counters only advance while staying in RUN, so every entry to RUN
        // starts a fresh frame at div=0, bit=0.
        if (cont_run) begin
            if (div_cnt == DIV_LAST) begin
                div_nx = '0;
                bit_nx = bit_cnt + 1'b1;
            end else begin
                div_nx = div_cnt + 1'b1;
                bit_nx = bit_cnt;
            end
        end

        // Accept implies the holding register was empty, so it never
        // collides with a load that consumes a full holding register.
        if (!active_nx)
            hold_full_nx = 1'b0;
        else if (accept)
            hold_full_nx = 1'b1;
        else if (load)
            hold_full_nx = 1'b0;

        ready_nx    = active_nx && !hold_full_nx;
        underrun_nx = cont_run && (div_nx == '0) && (bit_nx == '0) && !hold_full_nx;

        // Outputs are registered from the next counter values so that the
        // pins line up with the counters in the cycle they describe.
        if (run_nx) begin
            bclk_nx = (div_nx >= DIV_HALF);
            lrck_nx = bit_nx[5];
            slot_k  = bit_nx[4:0];
            sr_sel  = bit_nx[5] ? right_sr : left_sr;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (slot_k == 5'(DATA_WIDTH - i))
                    dat_nx = sr_sel[i];
            end
        end
    end

    // Control state, counters and registered codec outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT_LOCK;
            stable_cnt   <= '0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            hold_full    <= 1'b0;
            sample_ready <= 1'b0;
            aud_bclk     <= 1'b0;
            aud_daclrck  <= 1'b0;
            aud_dacdat   <= 1'b0;
            underrun     <= 1'b0;
            running      <= 1'b0;
        end else begin
            state        <= state_nx;
            stable_cnt   <= stable_cnt_nx;
            div_cnt      <= div_nx;
            bit_cnt      <= bit_nx;
            hold_full    <= hold_full_nx;
            sample_ready <= ready_nx;
            aud_bclk     <= bclk_nx;
            aud_daclrck  <= lrck_nx;
            aud_dacdat   <= dat_nx;
            underrun     <= underrun_nx;
            running      <= run_nx;
        end
    end

    // Frame load: take the held pair, or silence when nothing is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_sr  <= '0;
            right_sr <= '0;
        end else if (load) begin
            left_sr  <= hold_full ? hold_left  : '0;
            right_sr <= hold_full ? hold_right : '0;
        end
    end

    // Holding register data; its occupancy is tracked by hold_full.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_left  <= left_data;
            hold_right <= right_data;
        end
    end

endmodule

// File: tb/tb_audio_i2s_dac_tx.sv
// Directed testbench for audio_i2s_dac_tx (DATA_WIDTH=24, BCLK_DIV=6,
// LOCK_STABLE_CYCLES=16). Frames are compared cycle by cycle against
// waveforms the bench computes from the frame position and sample values.
module tb_audio_i2s_dac_tx;

    localparam int DW    = 24;
    localparam int DIV   = 6;
    localparam int FRAME = 64 * DIV;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pll_locked;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          sample_valid;
    logic          sample_ready;
    logic          aud_bclk;
    logic          aud_daclrck;
    logic          aud_dacdat;
    logic          underrun;
    logic          running;

    int n_assert = 0;
    int n_fail   = 0;
    int feed_n   = 0;
    int waited;
    int acc_cnt;

    audio_i2s_dac_tx #(
        .DATA_WIDTH        (DW),
        .BCLK_DIV          (DIV),
        .LOCK_STABLE_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .left_data   (left_data),
        .right_data  (right_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat),
        .underrun    (underrun),
        .running     (running)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] feed_left(input int n);
        return 24'h800001 + DW'(n);
    endfunction

    function automatic logic [DW-1:0] feed_right(input int n);
        return 24'h0F00F0 + DW'(n);
    endfunction

    task automatic check_idle(input string tag);
        check_bit({tag, "_bclk"}, aud_bclk, 1'b0);
        check_bit({tag, "_lrck"}, aud_daclrck, 1'b0);
        check_bit({tag, "_dat"}, aud_dacdat, 1'b0);
        check_bit({tag, "_underrun"}, underrun, 1'b0);
        check_bit({tag, "_running"}, running, 1'b0);
        check_bit({tag, "_ready"}, sample_ready, 1'b0);
    endtask

    // Called in the frame-load cycle; leaves the bench in the next one.
    // Feeds incrementing samples whenever a handshake completes.
    task automatic check_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                               input logic exp_ur, output int accepts);
        int            b;
        int            k;
        logic [DW-1:0] smp;
        logic          e_dat;
        logic          acc;
        accepts = 0;
        for (int j = 0; j < FRAME; j++) begin
            b     = j / DIV;
            k     = b % 32;
            smp   = (b < 32) ? l : r;
            e_dat = (k >= 1 && k <= DW) ? smp[DW-k] : 1'b0;
            check_bit("frame_bclk", aud_bclk, (j % DIV) >= (DIV / 2));
            check_bit("frame_lrck", aud_daclrck, b >= 32);
            check_bit("frame_dat", aud_dacdat, e_dat);
            check_bit("frame_underrun", underrun, (j == 0) ? exp_ur : 1'b0);
            check_bit("frame_running", running, 1'b1);
            acc = sample_valid && sample_ready;
            tick();
            if (acc) begin
                accepts++;
                feed_n++;
                left_data  = feed_left(feed_n);
                right_data = feed_right(feed_n);
            end
        end
    endtask

    initial begin
        // Reset with the PLL unlocked.
        reset_n      = 1'b0;
        pll_locked   = 1'b0;
        sample_valid = 1'b0;
        left_data    = '0;
        right_data   = '0;
        repeat (100) tick();
        check_idle("reset");
        reset_n = 1'b1;
        repeat (10) tick();
        check_idle("unlocked");

        // Lock and prefill the holding register during STARTUP.
        pll_locked   = 1'b1;
        sample_valid = 1'b1;
        left_data    = 24'hA5A5A5;
        right_data   = 24'h5A5A5A;
        repeat (3) tick();
        check_bit("ready_startup", sample_ready, 1'b1);
        check_bit("running_startup", running, 1'b0);
        tick();
        check_bit("ready_prefilled", sample_ready, 1'b0);
        sample_valid = 1'b0;
        waited = 4;
        while (!running && waited < 40) begin
            tick();
            waited++;
        end
        check_bit("running_up", running, 1'b1);
        n_assert++;
        assert (waited >= 18 && waited <= 20)
        else begin
            n_fail++;
            $error("FAIL run_latency: observed %0d clk, expected 18..20", waited);
        end

        // Frame 0 carries the prefilled pair with no underrun.
        check_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0, acc_cnt);
        check_int("frame0_accepts", acc_cnt, 0);

        // No samples supplied: silent frames, one underrun each.
        check_bit("ready_empty", sample_ready, 1'b1);
        check_frame('0, '0, 1'b1, acc_cnt);
        check_int("frame1_accepts", acc_cnt, 0);
        check_frame('0, '0, 1'b1, acc_cnt);
        check_int("frame2_accepts", acc_cnt, 0);

        // Continuous supply: accept coincides with frame 3's load, so frame 3
        // is still silent and each later frame carries the previous accept.
        feed_n       = 0;
        left_data    = feed_left(0);
        right_data   = feed_right(0);
        sample_valid = 1'b1;
        check_frame('0, '0, 1'b1, acc_cnt);
        check_int("frame3_accepts", acc_cnt, 1);
        for (int f = 0; f < 3; f++) begin
            check_frame(feed_left(f), feed_right(f), 1'b0, acc_cnt);
            check_int("stream_accepts", acc_cnt, 1);
        end

        // Frame 7 load consumes sample 3; sample 4 is accepted one cycle later.
        tick();
        check_bit("ready_after_load", sample_ready, 1'b1);
        tick();
        sample_valid = 1'b0;
        check_bit("ready_held", sample_ready, 1'b0);

        // Lose lock in the right slot while a sample is held.
        repeat (200) tick();
        check_bit("right_slot", aud_daclrck, 1'b1);
        pll_locked = 1'b0;
        repeat (3) tick();
        check_idle("unlock");

        // Relock: holding was flushed, so the first frame is silent, starts
        // with the left slot and reports no underrun.
        repeat (5) tick();
        pll_locked = 1'b1;
        repeat (3) tick();
        check_bit("ready_relock", sample_ready, 1'b1);
        waited = 3;
        while (!running && waited < 40) begin
            tick();
            waited++;
        end
        check_bit("running_relock", running, 1'b1);
        check_frame('0, '0, 1'b0, acc_cnt);
        check_int("relock_accepts", acc_cnt, 0);

        // Asynchronous reset in the middle of a frame.
        repeat (100) tick();
        check_bit("running_before_reset", running, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async_reset");
        reset_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
